mips_cpu: RTL and testbench

- Single-cycle 32-bit MIPS-subset processor core with Harvard-style ports: a combinational instruction port and a combinational data-memory port to an external word memory.
- One instruction retires per rising clock edge.
- Holds a 32x32 register file and a program counter.
- A halt instruction parks the PC at 0xFFFF_FFFF; the system bench treats that value as end-of-program and dumps the registers.

---
 rtl/mips_cpu_pkg.sv | 58 +++++
 rtl/mips_cpu_if.sv | 25 ++
 rtl/mips_cpu_reg_file.sv | 30 +++
 rtl/mips_cpu.sv | 161 ++++++++++++++++
 tb/tb_mips_cpu.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the mips_cpu core: opcodes, functs, ALU ops,
// the decoded control word and the default reset/halt PC values.
package mips_cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] HALT_PC_DEFAULT  = 32'hFFFF_FFFF;
  localparam int          NUM_REGS         = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_LUI
  } alu_op_e;

  // One decoded instruction; an all-zero word is a nop.
  typedef struct packed {
    logic       reg_write;
    logic [4:0] wr_addr;
    logic       wb_from_mem;
    alu_op_e    alu_op;
    logic       alu_src_imm;
    logic       imm_zext;
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic       halt;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_cpu_if.sv
// Instruction and data memory bus between the core (master) and memory (slave).
// Both ports are combinational: the slave answers instr/data_out in the same
// cycle the master drives addresses; a store is captured on the rising edge
// while mem_write is high. There is no stall, so no valid/ready pair exists.
interface mips_cpu_if;

  logic [31:0] inst_addr;
  logic [31:0] instr;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;

  modport master (
    output inst_addr, data_addr, data_in, mem_read, mem_write,
    input  instr, data_out
  );

  modport slave (
    input  inst_addr, data_addr, data_in, mem_read, mem_write,
    output instr, data_out
  );

endinterface

// File: rtl/mips_cpu_reg_file.sv
// 32x32 register file: two combinational read ports, one edge-triggered write
// port. R0 is hardwired to zero; reads during a write see the old value.
module mips_cpu_reg_file
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regFile [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else if (we && (wr_addr != 5'd0)) begin
      regFile[wr_addr] <= wr_data;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'h0 : regFile[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'h0 : regFile[rt_addr];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-subset core: decode, ALU and next-PC are combinational,
// PC and register file update on the rising edge. PC == HALT_PC is terminal.
module mips_cpu
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_PC  = HALT_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  mips_cpu_if.master bus,
  output logic       halted
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [31:0] br_off;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] wr_data;
  logic        taken;
  ctrl_t       ctrl;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] target;

  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign shamt  = bus.instr[10:6];
  assign funct  = bus.instr[5:0];
  assign imm16  = bus.instr[15:0];
  assign target = bus.instr[25:0];

  assign halted = (pc == HALT_PC);

  // Once halted the fetched word is ignored entirely.
  always_comb begin
    ctrl         = '0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.wr_addr = rt;
    if (!halted) begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.wr_addr = rd;
          case (funct)
            FN_ADD: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
            FN_SUB: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
            FN_AND: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
            FN_OR:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
            FN_SLT: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
            FN_SLL: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLL; end
            default: ;
          endcase
        end
        OP_ADDI: begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src_imm = 1'b1;
        end
        OP_ANDI: begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src_imm = 1'b1;
          ctrl.imm_zext    = 1'b1;
          ctrl.alu_op      = ALU_AND;
        end
        OP_ORI: begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src_imm = 1'b1;
          ctrl.imm_zext    = 1'b1;
          ctrl.alu_op      = ALU_OR;
        end
        OP_LUI: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_LUI;
        end
        OP_LW: begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src_imm = 1'b1;
          ctrl.wb_from_mem = 1'b1;
          ctrl.mem_read    = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_src_imm = 1'b1;
          ctrl.mem_write   = 1'b1;
        end
        OP_BEQ: ctrl.branch_eq = 1'b1;
        OP_BNE: ctrl.branch_ne = 1'b1;
        OP_J:   ctrl.jump      = 1'b1;
        OP_HLT: ctrl.halt      = 1'b1;
        default: ;
      endcase
    end
  end

  assign imm_ext = ctrl.imm_zext ? {16'h0, imm16} : sext16(imm16);
  assign alu_b   = ctrl.alu_src_imm ? imm_ext : rt_val;

  always_comb begin
    alu_y = 32'h0;
    case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLL: alu_y = rt_val << shamt;
      ALU_LUI: alu_y = {imm16, 16'h0};
      default: alu_y = 32'h0;
    endcase
  end

  // Branch offsets are always sign-extended, independent of imm_zext.
  assign br_off   = sext16(imm16) << 2;
  assign pc_plus4 = pc + 32'd4;
  assign taken    = (ctrl.branch_eq && (rs_val == rt_val)) ||
                    (ctrl.branch_ne && (rs_val != rt_val));

  always_comb begin
    next_pc = pc_plus4;
    if (halted || ctrl.halt) next_pc = HALT_PC;
    else if (ctrl.jump)      next_pc = {pc_plus4[31:28], target, 2'b00};
    else if (taken)          next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  assign wr_data = ctrl.wb_from_mem ? bus.data_out : alu_y;

  assign bus.inst_addr = pc;
  assign bus.data_addr = alu_y;
  assign bus.data_in   = rt_val;
  assign bus.mem_read  = ctrl.mem_read && !reset;
  assign bus.mem_write = ctrl.mem_write && !reset;

  mips_cpu_reg_file RegFile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_val),
    .rt_data (rt_val),
    .we      (ctrl.reg_write),
    .wr_addr (ctrl.wr_addr),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed programs plus random programs, every cycle
// compared against an instruction-level model of the architecture.
module tb_mips_cpu;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HALT_PC    = 32'hFFFF_FFFF;
  localparam logic [31:0] IMEM_END   = 32'h0000_3400;
  localparam int          IMEM_WORDS = 256;
  localparam int          DMEM_WORDS = 256;
  localparam logic [31:0] HLT        = 32'hFC00_0000;
  // Word presented at HALT_PC: a store that must be ignored once halted.
  localparam logic [31:0] HALT_BAIT  = 32'hAC21_0000;

  logic clk = 1'b0;
  logic reset;
  logic halted;
  logic dmem_clear;
  logic [31:0] dmem_seed;

  mips_cpu_if bus ();

  mips_cpu dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // ---------------- environment memories ----------------
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] ioff;

  function automatic logic [31:0] dmem_init(input int i, input logic [31:0] seed);
    return seed ^ (32'(i) * 32'h0001_0003) ^ 32'h00A5_0000;
  endfunction

  assign ioff = bus.inst_addr - RESET_PC;
  assign bus.instr = (bus.inst_addr == HALT_PC) ? HALT_BAIT :
                     ((bus.inst_addr >= RESET_PC) && (bus.inst_addr < IMEM_END)) ? imem[ioff[9:2]] :
                     32'h0;
  assign bus.data_out = dmem[bus.data_addr[9:2]];

  always @(posedge clk) begin
    if (dmem_clear) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= dmem_init(i, dmem_seed);
    end else if (bus.mem_write) begin
      dmem[bus.data_addr[9:2]] <= bus.data_in;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DMEM_WORDS];
  logic [31:0] m_pc;

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    logic [31:0] off;
    off = a - RESET_PC;
    if (a == HALT_PC) return HALT_BAIT;
    if ((a >= RESET_PC) && (a < IMEM_END)) return imem[off[9:2]];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    for (int i = 0; i < DMEM_WORDS; i++) m_dmem[i] = dmem_init(i, dmem_seed);
  endtask

  task automatic model_bus(output logic mr, output logic mw,
                           output logic [31:0] addr, output logic [31:0] wdata);
    logic [31:0] w;
    w = m_fetch(m_pc);
    mr = 1'b0; mw = 1'b0; addr = 32'h0; wdata = 32'h0;
    if (m_pc != HALT_PC) begin
      addr  = m_regs[w[25:21]] + {{16{w[15]}}, w[15:0]};
      wdata = m_regs[w[20:16]];
      mr    = (w[31:26] == 6'h23);
      mw    = (w[31:26] == 6'h2B);
    end
  endtask

  task automatic model_step();
    logic [31:0] w, a, b, simm, zimm, npc, res, ea;
    logic [15:0] imm;
    logic [4:0]  dst;
    bit          wr;
    if (m_pc == HALT_PC) return;
    w    = m_fetch(m_pc);
    imm  = w[15:0];
    a    = m_regs[w[25:21]];
    b    = m_regs[w[20:16]];
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0, imm};
    ea   = a + simm;
    npc  = m_pc + 32'd4;
    dst  = w[20:16];
    res  = 32'h0;
    wr   = 1'b0;
    case (w[31:26])
      6'h00: begin
        dst = w[15:11];
        wr  = 1'b1;
        case (w[5:0])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: res = b << w[10:6];
          default: wr = 1'b0;
        endcase
      end
      6'h08: begin wr = 1'b1; res = ea; end
      6'h0C: begin wr = 1'b1; res = a & zimm; end
      6'h0D: begin wr = 1'b1; res = a | zimm; end
      6'h0F: begin wr = 1'b1; res = {imm, 16'h0}; end
      6'h23: begin wr = 1'b1; res = m_dmem[ea[9:2]]; end
      6'h2B: m_dmem[ea[9:2]] = b;
      6'h04: if (a == b) npc = npc + (simm << 2);
      6'h05: if (a != b) npc = npc + (simm << 2);
      6'h02: npc = {npc[31:28], w[25:0], 2'b00};
      6'h3F: npc = HALT_PC;
      default: ;
    endcase
    if (wr && (dst != 5'd0)) m_regs[dst] = res;
    m_pc = npc;
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] addr);
    return {6'h02, addr[27:2]};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'h0;
  endtask

  logic [31:0] probe_pc;
  logic [31:0] probe_mw, probe_addr, probe_data;

  task automatic do_reset();
    int nz;
    reset = 1'b1;
    dmem_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.RegFile.regFile[i] != 32'h0) nz++;
    check("reset_pc", bus.inst_addr, RESET_PC);
    check("reset_mem_write", 32'(bus.mem_write), 32'd0);
    check("reset_mem_read", 32'(bus.mem_read), 32'd0);
    check("reset_regs_nonzero", 32'(nz), 32'd0);
    reset = 1'b0;
    dmem_clear = 1'b0;
    model_reset();
  endtask

  task automatic check_cycle();
    logic mr, mw;
    logic [31:0] addr, wdata;
    model_bus(mr, mw, addr, wdata);
    check("inst_addr", bus.inst_addr, m_pc);
    check("halted", 32'(halted), 32'(m_pc == HALT_PC));
    check("mem_read", 32'(bus.mem_read), 32'(mr));
    check("mem_write", 32'(bus.mem_write), 32'(mw));
    if (mr || mw) check("data_addr", bus.data_addr, addr);
    if (mw) check("data_in", bus.data_in, wdata);
    if (exp_q.size() > 0) check("pc_trace", bus.inst_addr, exp_q.pop_front());
    if (m_pc == probe_pc) begin
      probe_mw   = 32'(bus.mem_write);
      probe_addr = bus.data_addr;
      probe_data = bus.data_in;
    end
  endtask

  task automatic run(input int budget, input int hold);
    int extra;
    bit done;
    extra = 0;
    done  = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      check_cycle();
      if (m_pc == HALT_PC) begin
        if (extra >= hold) done = 1'b1;
        extra++;
      end
      if (!done) begin
        model_step();
        @(negedge clk);
      end
    end
    if (!done) check("run_budget", bus.inst_addr, HALT_PC);
  endtask

  task automatic check_state();
    for (int i = 0; i < 32; i++)
      check($sformatf("reg_r%0d", i), dut.RegFile.regFile[i], m_regs[i]);
    for (int i = 0; i < DMEM_WORDS; i++)
      check($sformatf("dmem_%0d", i), dmem[i], m_dmem[i]);
  endtask

  function automatic logic [31:0] rand_instr(input int idx);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int          k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    k   = $urandom_range(0, 3);
    case ($urandom_range(0, 15))
      0:  return enc_r(rs, rt, rd, 5'd0, 6'h20);
      1:  return enc_r(rs, rt, rd, 5'd0, 6'h22);
      2:  return enc_r(rs, rt, rd, 5'd0, 6'h24);
      3:  return enc_r(rs, rt, rd, 5'd0, 6'h25);
      4:  return enc_r(rs, rt, rd, 5'd0, 6'h2A);
      5:  return enc_r(5'd0, rt, rd, 5'($urandom_range(0, 31)), 6'h00);
      6:  return enc_i(6'h08, rs, rt, imm);
      7:  return enc_i(6'h0C, rs, rt, imm);
      8:  return enc_i(6'h0D, rs, rt, imm);
      9:  return enc_i(6'h0F, rs, rt, imm);
      10: return enc_i(6'h23, rs, rt, imm);
      11: return enc_i(6'h2B, rs, rt, imm);
      12: return enc_i(6'h04, rs, rt, 16'(k));
      13: return enc_i(6'h05, rs, rt, 16'(k));
      14: return enc_j(RESET_PC + 32'(4 * (idx + 1 + k)));
      default: return ($urandom_range(0, 1) == 0) ? enc_r(rs, rt, rd, 5'd0, 6'h21)
                                                   : enc_i(6'h3E, rs, rt, imm);
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    reset      = 1'b1;
    dmem_clear = 1'b1;
    dmem_seed  = 32'h1234_5678;
    probe_pc   = 32'h0;
    probe_mw   = 32'h0;
    probe_addr = 32'h0;
    probe_data = 32'h0;

    // Arithmetic
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    imem[3] = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h22);
    imem[4] = enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A);
    imem[5] = HLT;
    do_reset();
    run(50, 0);
    check_state();
    check("arith_r3", dut.RegFile.regFile[3], 32'h0000_0002);
    check("arith_r4", dut.RegFile.regFile[4], 32'hFFFF_FFF8);
    check("arith_r5", dut.RegFile.regFile[5], 32'h0000_0001);
    check("arith_pc", bus.inst_addr, HALT_PC);

    // Memory
    clear_imem();
    imem[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h0040);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'h1234);
    imem[2] = enc_i(6'h2B, 5'd1, 5'd2, 16'd4);
    imem[3] = enc_i(6'h23, 5'd1, 5'd3, 16'd4);
    imem[4] = HLT;
    probe_pc = RESET_PC + 32'd8;
    do_reset();
    run(50, 0);
    probe_pc = 32'h0;
    check_state();
    check("mem_sw_strobe", probe_mw, 32'd1);
    check("mem_sw_addr", probe_addr, 32'h0000_0044);
    check("mem_sw_data", probe_data, 32'h0000_1234);
    check("mem_r3", dut.RegFile.regFile[3], 32'h0000_1234);

    // Control flow
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
    imem[2] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    imem[3] = enc_j(RESET_PC + 32'h14);
    imem[4] = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
    imem[5] = enc_i(6'h05, 5'd1, 5'd1, 16'd1);
    imem[6] = enc_i(6'h08, 5'd0, 5'd4, 16'd4);
    imem[7] = HLT;
    exp_q = {32'h0000_3000, 32'h0000_3004, 32'h0000_300C, 32'h0000_3014,
             32'h0000_3018, 32'h0000_301C, 32'hFFFF_FFFF};
    do_reset();
    run(50, 0);
    check_state();
    check("flow_trace_left", 32'(exp_q.size()), 32'd0);
    check("flow_r2_skipped", dut.RegFile.regFile[2], 32'h0);
    check("flow_r3_skipped", dut.RegFile.regFile[3], 32'h0);
    check("flow_r4", dut.RegFile.regFile[4], 32'h0000_0004);

    // R0 and halt hold
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[1] = HLT;
    do_reset();
    run(50, 5);
    check_state();
    check("r0_zero", dut.RegFile.regFile[0], 32'h0);
    check("halt_pc_hold", bus.inst_addr, HALT_PC);
    check("halt_no_write", 32'(bus.mem_write), 32'd0);
    check("halt_no_read", 32'(bus.mem_read), 32'd0);

    // Reset during a store
    clear_imem();
    imem[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h0040);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
    imem[2] = enc_i(6'h2B, 5'd1, 5'd2, 16'd0);
    imem[3] = enc_i(6'h08, 5'd0, 5'd3, 16'd9);
    imem[4] = HLT;
    do_reset();
    repeat (2) begin
      check_cycle();
      model_step();
      @(negedge clk);
    end
    check("mid_sw_strobe", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_sw_masked", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    check("mid_pc", bus.inst_addr, RESET_PC);
    check("mid_r1", dut.RegFile.regFile[1], 32'h0);
    check("mid_r2", dut.RegFile.regFile[2], 32'h0);
    check("mid_dmem", dmem[16], dmem_init(16, dmem_seed));
    reset = 1'b0;

    // Random programs
    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(24, 40);
      clear_imem();
      for (int i = 0; i < len; i++) imem[i] = rand_instr(i);
      for (int i = len; i < len + 6; i++) imem[i] = HLT;
      dmem_seed = $urandom;
      do_reset();
      run(300, 2);
      check_state();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
